dlsc_axi_rd_splitter: RTL and testbench

Per-master read-command splitter placed directly upstream of one router read input. Accepts long read bursts (IN_LEN length bits) from a master and issues router-legal bursts (OUT_LEN length bits) that never cross a 2^BOUNDARY-byte address boundary. Returns read data to the master unchanged, except that r_last is asserted only on the final beat of each original burst. Internal bursts are therefore invisible to the master.

---
 rtl/dlsc_axi_rd_splitter.sv | 166 ++++++++++++++++
 tb/tb_dlsc_axi_rd_splitter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_axi_rd_splitter.sv
// dlsc_axi_rd_splitter
// Splits long AXI read bursts from one master into router-legal bursts that
// never cross a 2^BOUNDARY-byte boundary. Read data is returned unchanged,
// except that r_last is raised only on the final beat of the original burst.
// A small FIFO remembers, per issued split, whether it ends the original burst.

module dlsc_axi_rd_splitter #(
    parameter int ADDR     = 32,
    parameter int DATA     = 32,
    parameter int IN_LEN   = 8,
    parameter int OUT_LEN  = 4,
    parameter int BOUNDARY = 12,
    parameter int MOT      = 16
) (
    input  logic                clk,
    input  logic                rst,

    output logic                in_ar_ready,
    input  logic                in_ar_valid,
    input  logic [ADDR-1:0]     in_ar_addr,
    input  logic [IN_LEN-1:0]   in_ar_len,

    input  logic                in_r_ready,
    output logic                in_r_valid,
    output logic                in_r_last,
    output logic [DATA-1:0]     in_r_data,
    output logic [1:0]          in_r_resp,

    input  logic                out_ar_ready,
    output logic                out_ar_valid,
    output logic [ADDR-1:0]     out_ar_addr,
    output logic [OUT_LEN-1:0]  out_ar_len,

    output logic                out_r_ready,
    input  logic                out_r_valid,
    input  logic                out_r_last,
    input  logic [DATA-1:0]     out_r_data,
    input  logic [1:0]          out_r_resp
);

    localparam int SH = $clog2(DATA / 8);
    // Wide enough for the remaining count, the boundary distance and MAXB
    localparam int BW = ((IN_LEN + 1) > (BOUNDARY + 1)) ? (IN_LEN + 1) : (BOUNDARY + 1);
    localparam logic [BW-1:0] MAXB = {{(BW-1){1'b0}}, 1'b1} << OUT_LEN;
    localparam int PW = $clog2(MOT);
    localparam logic [BOUNDARY:0] BND_BYTES = {1'b1, {BOUNDARY{1'b0}}};

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t             state;
    logic [ADDR-1:0]    cur_addr;
    logic [IN_LEN:0]    rem;
    logic [BOUNDARY:0]  bnd_bytes;
    logic [BW-1:0]      bnd;
    logic [BW-1:0]      beats;
    logic [BW-1:0]      beats_r;
    logic               final_r;

    logic               fifo_mem [MOT];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_head;
    logic               push;
    logic               pop;

    function automatic logic [BW-1:0] min3(input logic [BW-1:0] a,
                                           input logic [BW-1:0] b,
                                           input logic [BW-1:0] c);
        logic [BW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Size of the next split: limited by remaining beats, max router burst and boundary
    always_comb begin
        bnd_bytes = BND_BYTES - {1'b0, cur_addr[BOUNDARY-1:0]};
        bnd       = BW'(bnd_bytes >> SH);
        beats     = min3(BW'(rem), MAXB, bnd);
    end

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == (PW+1)'(MOT));
    assign fifo_head   = fifo_mem[rd_ptr];
    assign push        = out_ar_valid & out_ar_ready;
    assign pop         = out_r_valid & out_r_ready & out_r_last;

    assign in_ar_ready = rst & (state == IDLE);
    assign in_r_valid  = rst & out_r_valid & ~fifo_empty;
    assign out_r_ready = rst & in_r_ready & ~fifo_empty;
    assign in_r_data   = out_r_data;
    assign in_r_resp   = out_r_resp;
    assign in_r_last   = out_r_last & fifo_head;

    // Command FSM: accept a master burst, then issue one split at a time
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            out_ar_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ar_valid) begin
                        cur_addr <= in_ar_addr;
                        rem      <= {1'b0, in_ar_len} + (IN_LEN+1)'(1);
                        state    <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (!out_ar_valid) begin
                        // Only raise a split when its tracking entry is guaranteed a slot
                        if (!fifo_full) begin
                            out_ar_valid <= 1'b1;
                            out_ar_addr  <= cur_addr;
                            out_ar_len   <= OUT_LEN'(beats - BW'(1));
                            beats_r      <= beats;
                            final_r      <= (beats == BW'(rem));
                        end
                    end else if (out_ar_ready) begin
                        out_ar_valid <= 1'b0;
                        cur_addr     <= cur_addr + (ADDR'(beats_r) << SH);
                        rem          <= rem - beats_r[IN_LEN:0];
                        if (rem == beats_r[IN_LEN:0]) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tracking FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Tracking FIFO storage: one 'final' flag per issued split
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= final_r;
        end
    end

endmodule

// File: tb/tb_dlsc_axi_rd_splitter.sv
// Testbench for dlsc_axi_rd_splitter: directed and randomized bursts checked
// against a reference model of the split rules and of master-visible beats.

module tb_dlsc_axi_rd_splitter;

    localparam int MOT = 2;

    logic        clk;
    logic        rst;
    logic        in_ar_ready;
    logic        in_ar_valid;
    logic [31:0] in_ar_addr;
    logic [7:0]  in_ar_len;
    logic        in_r_ready;
    logic        in_r_valid;
    logic        in_r_last;
    logic [31:0] in_r_data;
    logic [1:0]  in_r_resp;
    logic        out_ar_ready;
    logic        out_ar_valid;
    logic [31:0] out_ar_addr;
    logic [3:0]  out_ar_len;
    logic        out_r_ready;
    logic        out_r_valid;
    logic        out_r_last;
    logic [31:0] out_r_data;
    logic [1:0]  out_r_resp;

    dlsc_axi_rd_splitter #(
        .ADDR(32), .DATA(32), .IN_LEN(8), .OUT_LEN(4), .BOUNDARY(12), .MOT(MOT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_ar_ready(in_ar_ready), .in_ar_valid(in_ar_valid),
        .in_ar_addr(in_ar_addr), .in_ar_len(in_ar_len),
        .in_r_ready(in_r_ready), .in_r_valid(in_r_valid), .in_r_last(in_r_last),
        .in_r_data(in_r_data), .in_r_resp(in_r_resp),
        .out_ar_ready(out_ar_ready), .out_ar_valid(out_ar_valid),
        .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len),
        .out_r_ready(out_r_ready), .out_r_valid(out_r_valid), .out_r_last(out_r_last),
        .out_r_data(out_r_data), .out_r_resp(out_r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending master commands, expected splits, expected master beats
    logic [31:0] mq_addr[$];
    logic [7:0]  mq_len[$];
    logic [31:0] es_addr[$];
    logic [3:0]  es_len[$];
    logic [31:0] eb_data[$];
    logic        eb_last[$];
    // Router: accepted splits and current beat index
    logic [31:0] rq_addr[$];
    logic [3:0]  rq_len[$];
    int          rbeat = 0;
    // Log of issued splits for directed checks
    logic [31:0] log_addr[$];
    logic [3:0]  log_len[$];
    int          nlast = 0;

    bit          rnd = 0;
    bit          r_hold = 0;
    bit          stab = 0;
    bit          r_cons = 0;
    logic [31:0] p_addr;
    logic [3:0]  p_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: split list and master beat list from the burst rules
    task automatic expect_cmd(input logic [31:0] addr, input logic [7:0] len);
        int unsigned rem, bnd, b;
        logic [31:0] a;
        rem = len + 1;
        a   = addr;
        while (rem > 0) begin
            bnd = (4096 - int'(a[11:0])) / 4;
            b = rem;
            if (b > 16)  b = 16;
            if (b > bnd) b = bnd;
            es_addr.push_back(a);
            es_len.push_back(4'(b - 1));
            a   = a + 32'(b * 4);
            rem = rem - b;
        end
        for (int i = 0; i <= int'(len); i++) begin
            eb_data.push_back(addr + 32'(i * 4));
            eb_last.push_back(i == int'(len));
        end
    endtask

    task automatic flush();
        mq_addr.delete(); mq_len.delete();
        es_addr.delete(); es_len.delete();
        eb_data.delete(); eb_last.delete();
        rq_addr.delete(); rq_len.delete();
        rbeat = 0;
        stab  = 0;
    endtask

    // One clock: observe handshakes at negedge, drive new inputs after posedge
    task automatic cycle();
        logic [31:0] d;
        logic        l;
        @(negedge clk);
        r_cons = 0;
        if (rst) begin
            if (stab)
                chk("ar_stable", {out_ar_valid, out_ar_addr, out_ar_len}, {1'b1, p_addr, p_len});
            stab   = out_ar_valid && !out_ar_ready;
            p_addr = out_ar_addr;
            p_len  = out_ar_len;
            if (out_ar_valid && out_ar_ready) begin
                chk("ar_expected", es_addr.size() != 0, 1);
                if (es_addr.size() != 0)
                    chk("ar_cmd", {out_ar_addr, out_ar_len}, {es_addr.pop_front(), es_len.pop_front()});
                rq_addr.push_back(out_ar_addr);
                rq_len.push_back(out_ar_len);
                log_addr.push_back(out_ar_addr);
                log_len.push_back(out_ar_len);
            end
            if (in_r_valid && in_r_ready) begin
                chk("r_expected", eb_data.size() != 0, 1);
                if (eb_data.size() != 0) begin
                    d = eb_data.pop_front();
                    l = eb_last.pop_front();
                    chk("r_beat", {in_r_data, in_r_resp, in_r_last}, {d, d[5:4], l});
                end
                if (in_r_last) nlast++;
            end
            if (out_r_valid && out_r_ready && rq_addr.size() != 0) begin
                r_cons = 1;
                if (rbeat == int'(rq_len[0])) begin
                    void'(rq_addr.pop_front());
                    void'(rq_len.pop_front());
                    rbeat = 0;
                end else begin
                    rbeat++;
                end
            end
            if (in_ar_valid && in_ar_ready && mq_addr.size() != 0)
                expect_cmd(mq_addr.pop_front(), mq_len.pop_front());
        end else begin
            stab = 0;
        end
        @(posedge clk);
        #1;
        out_ar_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_r_ready   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (r_hold || rq_addr.size() == 0)
            out_r_valid = 1'b0;
        else if (out_r_valid && !r_cons)
            out_r_valid = 1'b1;
        else
            out_r_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rq_addr.size() != 0) begin
            out_r_data = rq_addr[0] + 32'(rbeat * 4);
            out_r_last = (rbeat == int'(rq_len[0]));
        end else begin
            out_r_data = '0;
            out_r_last = 1'b0;
        end
        out_r_resp = out_r_data[5:4];
        if (mq_addr.size() != 0) begin
            in_ar_valid = 1'b1;
            in_ar_addr  = mq_addr[0];
            in_ar_len   = mq_len[0];
        end else begin
            in_ar_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((mq_addr.size() + es_addr.size() + eb_data.size() + rq_addr.size()) != 0 && n < limit) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, mq_addr.size() + es_addr.size() + eb_data.size() + rq_addr.size(), 0);
    endtask

    task automatic start(input logic [31:0] a, input logic [7:0] l);
        mq_addr.push_back(a);
        mq_len.push_back(l);
    endtask

    initial begin
        logic [31:0] ra;
        logic [7:0]  rl;
        int          n;

        rst = 1'b0;
        in_ar_valid = 0; in_ar_addr = 0; in_ar_len = 0;
        in_r_ready = 1; out_ar_ready = 1;
        out_r_valid = 1; out_r_last = 1; out_r_data = 0; out_r_resp = 0;

        // Reset: combinational outputs gated even with upstream activity
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ar_ready", in_ar_ready, 0);
        chk("rst_in_r_valid", in_r_valid, 0);
        chk("rst_out_r_ready", out_r_ready, 0);
        chk("rst_out_ar_valid", out_ar_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_r_valid = 0;
        out_r_last = 0;
        #1;
        chk("release_in_ar_ready", in_ar_ready, 1);

        // Short burst: single split, last on beat 4
        log_addr.delete(); log_len.delete(); nlast = 0;
        start(32'h100, 8'd3);
        drain("t1", 200);
        chk("t1_nsplit", log_addr.size(), 1);
        chk("t1_split0", {log_addr[0], log_len[0]}, {32'h100, 4'd3});
        chk("t1_nlast", nlast, 1);

        // 64 beats -> four 16-beat splits, one master last
        log_addr.delete(); log_len.delete(); nlast = 0;
        start(32'h000, 8'd63);
        drain("t2", 500);
        chk("t2_nsplit", log_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t2_split", {log_addr[i], log_len[i]}, {32'(i * 64), 4'd15});
        chk("t2_nlast", nlast, 1);

        // Boundary crossing at 0x1000
        log_addr.delete(); log_len.delete(); nlast = 0;
        start(32'hFF8, 8'd7);
        drain("t3", 200);
        chk("t3_nsplit", log_addr.size(), 2);
        chk("t3_split0", {log_addr[0], log_len[0]}, {32'hFF8, 4'd1});
        chk("t3_split1", {log_addr[1], log_len[1]}, {32'h1000, 4'd5});
        chk("t3_nlast", nlast, 1);

        // Tracking FIFO full: no further splits until data returns
        log_addr.delete(); log_len.delete(); nlast = 0;
        r_hold = 1;
        start(32'h0, 8'd63);
        start(32'h1000, 8'd63);
        repeat (8) cycle();
        chk("t4_nsplit_held", log_addr.size(), MOT);
        repeat (20) begin
            cycle();
            chk("t4_ar_valid_low", out_ar_valid, 0);
            chk("t4_in_ar_ready_low", in_ar_ready, 0);
        end
        r_hold = 0;
        drain("t4", 2000);
        chk("t4_nsplit", log_addr.size(), 8);
        chk("t4_nlast", nlast, 2);

        // Randomized commands with random stalls on every handshake
        rnd = 1;
        nlast = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            ra[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) ra[11:6] = 6'h3F;
            if ($urandom_range(0, 15) == 0) rl = 8'($urandom_range(0, 255));
            else rl = 8'($urandom_range(0, 15));
            start(ra, rl);
        end
        drain("t5", 70000);
        chk("t5_nlast", nlast, 1000);
        rnd = 0;

        // Reset during the second split of a four-split burst
        log_addr.delete(); log_len.delete(); nlast = 0;
        start(32'h0, 8'd63);
        n = 0;
        while (log_addr.size() < 1 && n < 50) begin
            cycle();
            n++;
        end
        chk("t6_first_split", log_addr.size(), 1);
        cycle();
        chk("t6_second_valid", out_ar_valid, 1);
        rst = 1'b0;
        r_hold = 1;
        flush();
        cycle();
        rst = 1'b1;
        out_r_valid = 1'b1;
        in_r_ready = 1'b1;
        #1;
        chk("t6_ar_valid", out_ar_valid, 0);
        chk("t6_in_r_valid", in_r_valid, 0);
        chk("t6_out_r_ready", out_r_ready, 0);
        chk("t6_in_ar_ready", in_ar_ready, 1);
        out_r_valid = 1'b0;
        r_hold = 0;
        log_addr.delete(); log_len.delete(); nlast = 0;
        start(32'h200, 8'd0);
        drain("t6", 200);
        chk("t6_nsplit", log_addr.size(), 1);
        chk("t6_split0", {log_addr[0], log_len[0]}, {32'h200, 4'd0});
        chk("t6_nlast", nlast, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
